// File: rtl/rs_syndrome_pkg.sv
// Shared RS helpers: FSM encoding and GF(2^m) arithmetic used at elaboration time.
// Both the encoder and the syndrome block derive their constants from these functions.
package rs_syndrome_pkg;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    // Shift-and-add multiply; irrpol includes the x^m term so bit m clears on reduction.
    function automatic int gf_mul(input int a, input int b, input int m, input int irrpol);
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ x;
            x = x << 1;
            if (((x >> m) & 1) != 0) x = x ^ irrpol;
        end
        return r;
    endfunction

    function automatic int gf_alpha_pow(input int e, input int m, input int irrpol);
        int ord;
        int ee;
        int r;
        ord = (1 << m) - 1;
        ee  = e % ord;
        if (ee < 0) ee = ee + ord;
        r = 1;
        for (int i = 0; i < ee; i++) r = gf_mul(r, 2, m, irrpol);
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_if.sv
// Symbol stream in, syndrome result out. master drives symbols, slave is the syndrome block.
interface rs_syndrome_if #(
    parameter int m     = 8,
    parameter int check = 30,
    parameter int lw    = 8
);
    logic                       isop;
    logic                       ival;
    logic                       ieop;
    logic [m-1:0]               idat;
    logic                       osyn_val;
    logic [check-1:0][m-1:0]    osyn;
    logic                       oerr;
    logic [lw-1:0]              olen;
    logic                       olen_err;

    modport master (
        output isop, ival, ieop, idat,
        input  osyn_val, osyn, oerr, olen, olen_err
    );

    modport slave (
        input  isop, ival, ieop, idat,
        output osyn_val, osyn, oerr, olen, olen_err
    );
endinterface

// File: rtl/rs_syndrome_cell.sv
// One Horner accumulator S <= S*alpha^rexp ^ d. onxt is the value after the current
// symbol so the top can capture a finished syndrome on the ieop cycle itself.
module rs_syndrome_cell
    import rs_syndrome_pkg::*;
#(
    parameter int m      = 8,
    parameter int irrpol = 285,
    parameter int rexp   = 0
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         iclkena,
    input  logic         iload,
    input  logic         istep,
    input  logic [m-1:0] idat,
    output logic [m-1:0] onxt
);

    // Column i is root * x^i; the constant multiply is the XOR of the columns
    // selected by the accumulator bits.
    function automatic logic [m-1:0][m-1:0] mk_cols();
        logic [m-1:0][m-1:0] c;
        int root;
        int t;
        root = gf_alpha_pow(rexp, m, irrpol);
        for (int i = 0; i < m; i++) begin
            t    = gf_mul(root, 1 << i, m, irrpol);
            c[i] = t[m-1:0];
        end
        return c;
    endfunction

    localparam logic [m-1:0][m-1:0] COLS = mk_cols();

    logic [m-1:0] acc;
    logic [m-1:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < m; i++)
            if (acc[i]) prod = prod ^ COLS[i];
        onxt = iload ? idat : (prod ^ idat);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)                          acc <= '0;
        else if (iclkena && (iload || istep)) acc <= onxt;
    end

endmodule

// File: rtl/rs_syndrome.sv
// RS syndrome calculator: check parallel Horner cells, frame FSM, symbol counter and
// output registers that hold the last completed frame while the next one accumulates.
module rs_syndrome
    import rs_syndrome_pkg::*;
#(
    parameter int n         = 255,
    parameter int check     = 30,
    parameter int m         = 8,
    parameter int irrpol    = 285,
    parameter int genstart  = 0,
    parameter int rootspace = 1,
    localparam int LW       = $clog2(n + 1)
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         iclkena,
    rs_syndrome_if.slave bus
);

    localparam logic [LW-1:0] CNT_MAX = '1;

    state_t                   state_q, state_d;
    logic [LW-1:0]            cnt_q, cnt_inc, len_nxt;
    logic [check-1:0][m-1:0]  nxt;
    logic                     sop, step, done;

    logic                     syn_val_q;
    logic [check-1:0][m-1:0]  syn_q;
    logic                     err_q;
    logic [LW-1:0]            len_q;
    logic                     len_err_q;

    always_comb begin
        sop     = bus.ival & bus.isop;
        step    = bus.ival & ~bus.isop & (state_q == ACC);
        done    = bus.ival & bus.ieop & (bus.isop | (state_q == ACC));
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        len_nxt = bus.isop ? LW'(1) : cnt_inc;

        state_d = state_q;
        case (state_q)
            IDLE:    if (sop && !bus.ieop)       state_d = ACC;
            ACC:     if (bus.ival && bus.ieop)   state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)       state_q <= IDLE;
        else if (iclkena) state_q <= state_d;
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)                cnt_q <= '0;
        else if (iclkena && sop)   cnt_q <= LW'(1);
        else if (iclkena && step)  cnt_q <= cnt_inc;
    end

    for (genvar j = 0; j < check; j++) begin : g_cell
        rs_syndrome_cell #(
            .m      (m),
            .irrpol (irrpol),
            .rexp   (rootspace * (genstart + j))
        ) u_cell (
            .iclk    (iclk),
            .ireset  (ireset),
            .iclkena (iclkena),
            .iload   (sop),
            .istep   (step),
            .idat    (bus.idat),
            .onxt    (nxt[j])
        );
    end

    // Results are captured from the cells' next values, so they land with osyn_val.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            syn_val_q <= 1'b0;
            syn_q     <= '0;
            err_q     <= 1'b0;
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else if (iclkena) begin
            syn_val_q <= done;
            if (done) begin
                syn_q     <= nxt;
                err_q     <= |nxt;
                len_q     <= len_nxt;
                len_err_q <= (int'(len_nxt) > n) || (int'(len_nxt) <= check);
            end
        end
    end

    assign bus.osyn_val = syn_val_q;
    assign bus.osyn     = syn_q;
    assign bus.oerr     = err_q;
    assign bus.olen     = len_q;
    assign bus.olen_err = len_err_q;

endmodule

// File: tb/tb_rs_syndrome.sv
// Bench for rs_syndrome: codewords from a table-based RS encoder, syndromes from direct
// polynomial evaluation at each root, compared with the DUT frame by frame.
module tb_rs_syndrome;

    localparam int N = 255, CHK = 30, M = 8, IRR = 285, GS = 0, RS = 1, LW = 8;

    typedef logic [CHK-1:0][M-1:0] syn_t;
    typedef struct packed {
        syn_t          syn;
        logic          err;
        logic [LW-1:0] len;
        logic          lerr;
    } res_t;

    logic iclk = 1'b0;
    logic ireset = 1'b1;
    logic iclkena = 1'b0;

    rs_syndrome_if #(.m(M), .check(CHK), .lw(LW)) bus();

    rs_syndrome #(
        .n(N), .check(CHK), .m(M), .irrpol(IRR), .genstart(GS), .rootspace(RS)
    ) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .bus     (bus)
    );

    always #5 iclk = ~iclk;

    int   tests = 0;
    int   fails = 0;
    int   exp_t [0:509];
    int   log_t [0:255];
    int   g [0:CHK];
    int   fr [$];
    res_t got [$];

    // Record a result on every enabled edge that leaves osyn_val high.
    initial begin
        logic en;
        res_t r;
        forever begin
            @(posedge iclk);
            en = iclkena;
            #1;
            if (en && bus.osyn_val) begin
                r.syn  = bus.osyn;
                r.err  = bus.oerr;
                r.len  = bus.olen;
                r.lerr = bus.olen_err;
                got.push_back(r);
            end
        end
    end

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[log_t[a] + log_t[b]];
    endfunction

    function automatic int root_exp(input int j);
        return (RS * (GS + j)) % 255;
    endfunction

    task automatic build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i]       = x;
            exp_t[i + 255] = x;
            log_t[x]       = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ IRR;
        end
        for (int i = 0; i <= CHK; i++) g[i] = 0;
        g[0] = 1;
        for (int j = 0; j < CHK; j++) begin
            int r;
            r = exp_t[root_exp(j)];
            for (int i = j + 1; i > 0; i--) g[i] = g[i-1] ^ gmul(g[i], r);
            g[0] = gmul(g[0], r);
        end
    endtask

    // Systematic encode: data first, then the remainder of d(x)*x^CHK mod g(x).
    task automatic make_codeword(input int L);
        int p [CHK];
        int fb;
        fr.delete();
        for (int i = 0; i < CHK; i++) p[i] = 0;
        for (int k = 0; k < L - CHK; k++) begin
            int d;
            d = $urandom_range(0, 255);
            fr.push_back(d);
            fb = d ^ p[CHK-1];
            for (int i = CHK - 1; i > 0; i--) p[i] = p[i-1] ^ gmul(fb, g[i]);
            p[0] = gmul(fb, g[0]);
        end
        for (int i = CHK - 1; i >= 0; i--) fr.push_back(p[i]);
    endtask

    task automatic make_random(input int L);
        fr.delete();
        for (int k = 0; k < L; k++) fr.push_back($urandom_range(0, 255));
    endtask

    task automatic make_zero(input int L);
        fr.delete();
        for (int k = 0; k < L; k++) fr.push_back(0);
    endtask

    // S_j = r(alpha^e_j), symbol k carrying degree L-1-k.
    function automatic res_t model();
        res_t r;
        int   L;
        L = fr.size();
        for (int j = 0; j < CHK; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < L; k++)
                s = s ^ gmul(fr[k], exp_t[(root_exp(j) * (L - 1 - k)) % 255]);
            r.syn[j] = 8'(s);
        end
        r.err  = (r.syn != '0);
        r.len  = 8'(L);
        r.lerr = (L > N) || (L <= CHK);
        return r;
    endfunction

    task automatic send_range(input int lo, input int hi, input bit gaps, input bit idle_after);
        for (int k = lo; k < hi; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    iclkena  = $urandom_range(0, 1) == 1;
                    bus.ival = !iclkena;
                    bus.isop = 1'($urandom);
                    bus.ieop = 1'($urandom);
                    bus.idat = 8'($urandom);
                    @(negedge iclk);
                end
            end
            iclkena  = 1'b1;
            bus.ival = 1'b1;
            bus.isop = (k == 0);
            bus.ieop = (k == fr.size() - 1);
            bus.idat = 8'(fr[k]);
            @(negedge iclk);
        end
        if (idle_after) begin
            bus.ival = 1'b0;
            bus.isop = 1'b0;
            bus.ieop = 1'b0;
        end
    endtask

    task automatic settle();
        iclkena  = 1'b1;
        bus.ival = 1'b0;
        bus.isop = 1'b0;
        bus.ieop = 1'b0;
        repeat (3) @(negedge iclk);
    endtask

    task automatic test_reset();
        ireset = 1'b1;
        iclkena = 1'b0;
        repeat (2) @(negedge iclk);
        tests++; if (bus.osyn_val !== 1'b0) begin fails++; $display("FAIL reset_val got %b want 0", bus.osyn_val); end
        tests++; if (bus.osyn !== syn_t'(0)) begin fails++; $display("FAIL reset_syn got %h want 0", bus.osyn); end
        tests++; if (bus.oerr !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.oerr); end
        tests++; if (bus.olen !== 8'd0) begin fails++; $display("FAIL reset_len got %0d want 0", bus.olen); end
        tests++; if (bus.olen_err !== 1'b0) begin fails++; $display("FAIL reset_lerr got %b want 0", bus.olen_err); end
        ireset = 1'b0;
        iclkena = 1'b1;
        @(negedge iclk);
    endtask

    task automatic test_zero();
        res_t c;
        got.delete();
        make_zero(255);
        send_range(0, 255, 1'b0, 1'b1);
        tests++; if (bus.osyn_val !== 1'b1) begin fails++; $display("FAIL zero_latency got %b want 1", bus.osyn_val); end
        @(negedge iclk);
        tests++; if (bus.osyn_val !== 1'b0) begin fails++; $display("FAIL zero_pulse got %b want 0", bus.osyn_val); end
        c = '{syn: '0, err: 1'b0, len: 8'd255, lerr: 1'b0};
        tests++;
        if (got.size() != 1 || got[0] !== c) begin
            fails++; $display("FAIL zero_frame n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
        repeat (5) @(negedge iclk);
        tests++; if (bus.olen !== 8'd255 || bus.osyn !== syn_t'(0)) begin fails++; $display("FAIL zero_hold len %0d want 255", bus.olen); end
    endtask

    task automatic test_single_err();
        res_t c;
        syn_t s;
        got.delete();
        make_zero(255);
        fr[254] = 1;
        send_range(0, 255, 1'b0, 1'b1);
        settle();
        for (int j = 0; j < CHK; j++) s[j] = 8'h01;
        c = '{syn: s, err: 1'b1, len: 8'd255, lerr: 1'b0};
        tests++;
        if (got.size() != 1 || got[0] !== c) begin
            fails++; $display("FAIL err_last n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
        got.delete();
        fr[254] = 0;
        fr[0]   = 1;
        c = model();
        send_range(0, 255, 1'b0, 1'b1);
        settle();
        tests++;
        if (got.size() != 1) begin
            fails++; $display("FAIL err_first count got %0d want 1", got.size());
        end else begin
            if (got[0].syn[0] !== 8'h01 || got[0].syn[1] !== 8'h8e || got[0].err !== 1'b1) begin
                fails++; $display("FAIL err_first S0=%h S1=%h err=%b want 01 8e 1", got[0].syn[0], got[0].syn[1], got[0].err);
            end
            tests++;
            if (got[0] !== c) begin fails++; $display("FAIL err_first_model got %h want %h", got[0], c); end
        end
    endtask

    task automatic test_back_to_back();
        res_t expq [$];
        got.delete();
        for (int f = 0; f < 4; f++) begin
            make_codeword(f == 2 ? 120 : 255);
            expq.push_back(model());
            send_range(0, fr.size(), 1'b0, f == 3);
        end
        settle();
        tests++;
        if (got.size() != 4) begin
            fails++; $display("FAIL b2b_count got %0d want 4", got.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                tests++;
                if (got[f].syn !== syn_t'(0) || got[f].err !== 1'b0 || got[f] !== expq[f]) begin
                    fails++; $display("FAIL b2b_frame%0d got %h want %h", f, got[f], expq[f]);
                end
            end
        end
    endtask

    task automatic test_shortened();
        res_t c;
        got.delete();
        make_codeword(40);
        send_range(0, 40, 1'b0, 1'b1);
        settle();
        c = '{syn: '0, err: 1'b0, len: 8'd40, lerr: 1'b0};
        tests++;
        if (got.size() != 1 || got[0] !== c) begin
            fails++; $display("FAIL short40 n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
        got.delete();
        make_random(20);
        c = model();
        send_range(0, 20, 1'b0, 1'b1);
        settle();
        tests++;
        if (got.size() != 1 || got[0] !== c || got[0].lerr !== 1'b1) begin
            fails++; $display("FAIL short20 n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
        got.delete();
        make_random(1);
        fr[0] = $urandom_range(1, 255);
        c = model();
        send_range(0, 1, 1'b0, 1'b1);
        settle();
        tests++;
        if (got.size() != 1 || got[0] !== c || got[0].len !== 8'd1 || got[0].lerr !== 1'b1) begin
            fails++; $display("FAIL one_sym n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
    endtask

    task automatic test_restart();
        res_t c;
        got.delete();
        make_random(255);
        send_range(0, 100, 1'b0, 1'b0);
        make_codeword(255);
        c = model();
        send_range(0, 255, 1'b0, 1'b1);
        settle();
        tests++;
        if (got.size() != 1 || got[0] !== c || got[0].syn !== syn_t'(0) || got[0].len !== 8'd255) begin
            fails++; $display("FAIL restart n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
    endtask

    task automatic test_gaps_reset();
        res_t c;
        res_t expq [$];
        got.delete();
        make_random(255);
        c = model();
        send_range(0, 255, 1'b1, 1'b1);
        settle();
        tests++;
        if (got.size() != 1 || got[0] !== c) begin
            fails++; $display("FAIL gaps_rand n=%0d got %h want %h", got.size(), got.size() ? got[0] : res_t'(0), c);
        end
        got.delete();
        make_codeword(255);
        send_range(0, 50, 1'b1, 1'b0);
        ireset = 1'b1;
        @(negedge iclk);
        ireset = 1'b0;
        tests++;
        if (bus.olen !== 8'd0 || bus.osyn !== syn_t'(0) || bus.oerr !== 1'b0) begin
            fails++; $display("FAIL midreset_clear len %0d err %b want 0 0", bus.olen, bus.oerr);
        end
        send_range(50, 255, 1'b1, 1'b1);
        settle();
        tests++;
        if (got.size() != 0) begin fails++; $display("FAIL midreset_noval got %0d want 0", got.size()); end
        got.delete();
        make_codeword(255);
        expq.push_back(model());
        send_range(0, 255, 1'b1, 1'b1);
        make_random(100);
        expq.push_back(model());
        send_range(0, 100, 1'b1, 1'b1);
        settle();
        tests++;
        if (got.size() != 2) begin
            fails++; $display("FAIL gaps_count got %0d want 2", got.size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                tests++;
                if (got[f] !== expq[f]) begin fails++; $display("FAIL gaps_frame%0d got %h want %h", f, got[f], expq[f]); end
            end
        end
    endtask

    initial begin
        bus.ival = 1'b0;
        bus.isop = 1'b0;
        bus.ieop = 1'b0;
        bus.idat = '0;
        build_tables();
        test_reset();
        test_zero();
        test_single_err();
        test_back_to_back();
        test_shortened();
        test_restart();
        test_gaps_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_syndrome.md
RS_SYNDROME -- requirements
Module: rs_syndrome

Interface
REQ-001 Parameter n, default 255, full codeword length in symbols.
REQ-002 Parameter check, default 30, number of parity symbols (= number of syndromes).
REQ-003 Parameter m, default 8, symbol width in bits.
REQ-004 Parameter irrpol, default 285, GF(2^m) primitive polynomial.
REQ-005 Parameter genstart, default 0, first generator root exponent.
REQ-006 Parameter rootspace, default 1, root exponent spacing.
REQ-007 iclk  in  1  sole clock; all state changes on its rising edge.
REQ-008 ireset  in  1  asynchronous, active-high reset.
REQ-009 iclkena  in  1  clock enable; when low all state holds.
REQ-010 isop  in  1  first symbol of frame, qualified by ival.
REQ-011 ival  in  1  symbol valid.
REQ-012 ieop  in  1  last symbol of frame, qualified by ival.
REQ-013 idat  in  m  received symbol, highest-degree coefficient first.
REQ-014 osyn_val  out  1  one-cycle pulse: syndrome outputs valid.
REQ-015 osyn  out  check x m  syndromes S_0..S_(check-1).
REQ-016 oerr  out  1  at least one syndrome nonzero.
REQ-017 olen  out  clog2(n+1)  received symbol count of the frame.
REQ-018 olen_err  out  1  olen > n or olen <= check.

Function
REQ-019 Root j SHALL be alpha^(rootspace*(genstart+j)), j = 0..check-1, matching the team RS encoder generator for identical parameters.
REQ-020 FSM states IDLE and ACC; IDLE->ACC on ival&isop&!ieop; ACC->IDLE on ival&ieop; all other cases hold.
REQ-021 On ival&isop: S_j <= idat for all j, symbol counter <= 1 (restart even if in ACC; partial frame discarded, no osyn_val).
REQ-022 In ACC on ival&!isop: S_j <= S_j * root_j XOR idat (Horner), counter increments, saturating at 2^width-1.
REQ-023 ival&ieop (in ACC or with isop) SHALL complete the frame including that symbol; outputs update and osyn_val pulses high exactly one cycle later (latency 1 from last symbol).
REQ-024 isop&ieop same cycle: one-symbol frame; olen=1, olen_err=1.
REQ-025 ival in IDLE without isop: symbol ignored, no state change.
REQ-026 ival low: no accumulation, counter holds; gaps of any length allowed.
REQ-027 osyn, oerr, olen, olen_err SHALL hold their last values until the next frame completes; accumulators are separate from output registers so a new frame may start the cycle after ieop.
REQ-028 GF multiplies by root_j SHALL be constant multiplies (XOR networks) computed at elaboration; no tables in hardware.
REQ-029 Shortened frames (check < olen <= n) SHALL be valid; syndromes equal those of the zero-prefixed full codeword.

Reset
REQ-030 On ireset: osyn_val=0, osyn=all zero, oerr=0, olen=0, olen_err=0, FSM=IDLE, accumulators and counter zero, regardless of iclkena.
REQ-031 Reset mid-frame discards the frame; no osyn_val issued for it.

Structure
REQ-032 Parameter set, symbol/syndrome array typedefs and GF functions (alpha table generation, constant multiply) SHALL come from the shared RS parameter/function includes already used by the encoder.
REQ-033 One sub-module rs_syndrome_cell (one Horner accumulator, parameterised by root exponent) instantiated check times via generate.

Verification (n=255, check=30, m=8, irrpol=285, genstart=0, rootspace=1)
REQ-034 255 zero symbols -> osyn_val one cycle after ieop, all S_j=0x00, oerr=0, olen=255, olen_err=0.
REQ-035 Encoder output for random data fed back-to-back -> all S_j=0x00, oerr=0 every frame, no idle cycle between frames.
REQ-036 Zero codeword with 0x01 on last symbol -> all S_j=0x01; 0x01 on first symbol -> S_0=0x01, S_1=0x8E, oerr=1.
REQ-037 Shortened 40-symbol encoder frame -> all S_j=0x00, olen=40, olen_err=0; 20-symbol frame -> olen_err=1.
REQ-038 isop reasserted at symbol 100 of a frame, then full 255-symbol codeword -> single osyn_val, olen=255, syndromes of second frame only.
REQ-039 Random ival gaps and iclkena low cycles, plus ireset at symbol 50 -> outputs match gap-free reference; reset frame yields no osyn_val.
